// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation search controller.
package sar_pkg;
    typedef enum logic [1:0] {IDLE, PROBE, DONE} sar_state_e;

    localparam int SAR_W_DEF      = 4;
    localparam int SAR_SETTLE_DEF = 1;
endpackage

// File: rtl/sar_search_ctrl_if.sv
// Comparator-side and handshake signals of the search controller.
// SAR_ONEHOT_CHK_EN adds the cmp_err flag.
interface sar_search_ctrl_if
    import sar_pkg::*;
#(
    parameter int W = SAR_W_DEF
);
    logic         start;
    logic [W-1:0] guess;
    logic         cmp_lt;
    logic         cmp_eq;
    logic         cmp_gt;
    logic         busy;
    logic         done;
    logic         found;
    logic [W-1:0] result;
`ifdef SAR_ONEHOT_CHK_EN
    logic         cmp_err;
`endif

    modport master (
        input  start, cmp_lt, cmp_eq, cmp_gt,
        output guess, busy, done, found, result
`ifdef SAR_ONEHOT_CHK_EN
        , output cmp_err
`endif
    );

    modport slave (
        output start, cmp_lt, cmp_eq, cmp_gt,
        input  guess, busy, done, found, result
`ifdef SAR_ONEHOT_CHK_EN
        , input cmp_err
`endif
    );
endinterface

// File: rtl/sar_settle_timer.sv
// Counts cycles a probe has been held; sample pulses on the cycle the flags are valid.
module sar_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic sample
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en)    cnt <= cnt + CW'(1);
    end

    assign sample = en && (cnt == CW'(SETTLE - 1));
endmodule

// File: rtl/sar_search_ctrl.sv
// Binary-search initiator: probes a comparator until eq or the [lo,hi] window empties.
// Define SAR_ONEHOT_CHK_EN to abort on non-one-hot comparator flags (cmp_err).
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int W      = SAR_W_DEF,
    parameter int SETTLE = SAR_SETTLE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    sar_search_ctrl_if.master   bus
);
    localparam logic [W:0]   HI_MAX = {1'b0, {W{1'b1}}};
    localparam logic [W-1:0] MID0   = {1'b0, {(W-1){1'b1}}};

    sar_state_e   state_q, state_d;
    logic [W:0]   lo_q, lo_d, hi_q, hi_d;
    logic [W-1:0] guess_q, guess_d, result_q, result_d;
    logic         found_q, found_d, err_q, err_d;
    logic [W:0]   lo_n, hi_n;
    logic [W+1:0] sum;
    logic         sample, tmr_en, bad;

    assign tmr_en = (state_q == PROBE);

    sar_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!tmr_en || sample),
        .en     (tmr_en),
        .sample (sample)
    );

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        found_d  = found_q;
        result_d = result_q;
        err_d    = err_q;
        lo_n     = lo_q;
        hi_n     = hi_q;
        sum      = '0;
        bad      = 1'b0;
`ifdef SAR_ONEHOT_CHK_EN
        bad      = !$onehot({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt});
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                lo_d     = '0;
                hi_d     = HI_MAX;
                guess_d  = MID0;
                found_d  = 1'b0;
                result_d = '0;
                err_d    = 1'b0;
                state_d  = PROBE;
            end
            PROBE: if (sample) begin
                if (bad) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = '0;
                    state_d  = DONE;
                end else if (bus.cmp_eq) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    state_d  = DONE;
                end else if (!bus.cmp_lt && ({1'b0, guess_q} == lo_q)) begin
                    // gt at the bottom of the window: stop before hi underflows
                    found_d = 1'b0;
                    state_d = DONE;
                end else begin
                    if (bus.cmp_lt) lo_n = {1'b0, guess_q} + (W+1)'(1);
                    else            hi_n = {1'b0, guess_q} - (W+1)'(1);
                    lo_d = lo_n;
                    hi_d = hi_n;
                    if (lo_n > hi_n) begin
                        found_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        sum     = {1'b0, lo_n} + {1'b0, hi_n};
                        guess_d = W'(sum >> 1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= HI_MAX;
            guess_q  <= '0;
            found_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            found_q  <= found_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = (state_q == PROBE);
    assign bus.done   = (state_q == DONE);
    assign bus.found  = found_q;
    assign bus.result = result_q;
`ifdef SAR_ONEHOT_CHK_EN
    assign bus.cmp_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed and random searches against a behavioural comparator, scoreboard-checked.
module tb_sar_search_ctrl;
    localparam int W      = 4;
    localparam int SETTLE = 1;

    typedef struct {
        logic         found;
        logic [W-1:0] result;
        int           probes;   // 0 = only bound-checked
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] target = '0;
    logic [1:0]   mode = 2'd0;  // 0 real comparator, 1 stuck lt, 2 lt+gt
    exp_t         exp_q[$];
    logic [W-1:0] probe_q[$];
    int           compared = 0;
    int           mismatched = 0;

    sar_search_ctrl_if #(.W(W)) bus();

    assign bus.cmp_lt = (mode != 2'd0) ? 1'b1 : (bus.guess < target);
    assign bus.cmp_eq = (mode == 2'd0) && (bus.guess == target);
    assign bus.cmp_gt = (mode == 2'd2) ? 1'b1 : (mode == 2'd1) ? 1'b0 : (bus.guess > target);

    sar_search_ctrl #(.W(W), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic f, input logic [W-1:0] r, input int p);
        exp_t e;
        e.found = f; e.result = r; e.probes = p;
        exp_q.push_back(e);
    endtask

    task automatic run_search(input string tag, input bit repulse);
        int   cyc = 0;
        int   n = 0;
        exp_t e;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        forever begin
            cyc++;
            if (repulse) bus.start = (cyc == 2);
            if (bus.busy) begin
                n++;
                if (probe_q.size() > 0) check({tag, " probe"}, 32'(bus.guess), 32'(probe_q.pop_front()));
            end
            if (bus.done || cyc > 40) break;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " latency"}, cyc, n * SETTLE + 1);
        check({tag, " found"}, 32'(bus.found), 32'(e.found));
        check({tag, " result"}, 32'(bus.result), 32'(e.result));
        if (e.probes > 0) check({tag, " nprobes"}, n, e.probes);
        else              check({tag, " nprobes<=W+1"}, 32'(n <= W + 1), 32'd1);
        check({tag, " probes left"}, probe_q.size(), 0);
        @(negedge clk);
        check({tag, " done pulse"}, {bus.done, bus.busy}, 32'd0);
        check({tag, " found held"}, 32'(bus.found), 32'(e.found));
    endtask

    initial begin
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset guess", 32'(bus.guess), 32'd0);
        check("reset busy/done", {bus.busy, bus.done}, 32'd0);
        check("reset found", 32'(bus.found), 32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        rst = 1'b0;

        target = 4'd9;  probe_q = '{4'd7, 4'd11, 4'd9};
        push_exp(1'b1, 4'd9, 3);  run_search("t9", 1'b0);

        target = 4'd0;  probe_q = '{4'd7, 4'd3, 4'd1, 4'd0};
        push_exp(1'b1, 4'd0, 4);  run_search("t0", 1'b0);

        target = 4'd15; probe_q = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        push_exp(1'b1, 4'd15, 5); run_search("t15", 1'b0);

        mode = 2'd1;    probe_q = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        push_exp(1'b0, 4'd0, 5);  run_search("stuck_lt", 1'b0);
        mode = 2'd0;

        target = 4'd9;  probe_q = '{4'd7, 4'd11, 4'd9};
        push_exp(1'b1, 4'd9, 3);  run_search("repulse", 1'b1);

        // reset during the second probe
        target = 4'd9;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        check("mid 2nd probe", 32'(bus.guess), 32'd11);
        rst = 1'b1;
        #1;
        check("midrst guess", 32'(bus.guess), 32'd0);
        check("midrst busy/done", {bus.busy, bus.done}, 32'd0);
        check("midrst found", 32'(bus.found), 32'd0);
        check("midrst result", 32'(bus.result), 32'd0);
        @(negedge clk); rst = 1'b0;
        target = 4'd5;  probe_q = '{4'd7, 4'd3, 4'd5};
        push_exp(1'b1, 4'd5, 3);  run_search("after_rst", 1'b0);

`ifdef SAR_ONEHOT_CHK_EN
        mode = 2'd2;    probe_q = '{4'd7};
        push_exp(1'b0, 4'd0, 1);  run_search("not_onehot", 1'b0);
        check("cmp_err set", 32'(bus.cmp_err), 32'd1);
        mode = 2'd0;
        target = 4'd6;  probe_q = '{4'd7, 4'd3, 4'd5, 4'd6};
        push_exp(1'b1, 4'd6, 4);  run_search("err_clear", 1'b0);
        check("cmp_err clear", 32'(bus.cmp_err), 32'd0);
`endif

        for (int i = 0; i < 100; i++) begin
            target = W'($urandom_range(0, 2**W - 1));
            push_exp(1'b1, target, 0);
            run_search("random", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
